// File: rtl/ps2_key_arbiter.sv
// Two-channel PS/2 key event scheduler: per-player FIFOs, round-robin output.
// Optional repeat filter: define KEY_ARB_REPEAT_FILTER_EN.
module ps2_key_arbiter #(
  parameter int DEPTH  = 4,
  parameter int CODE_W = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     p1_valid,
  input  logic [CODE_W-1:0]        p1_code,
  input  logic                     p2_valid,
  input  logic [CODE_W-1:0]        p2_code,
  output logic                     out_valid,
  output logic [CODE_W-1:0]        out_code,
  output logic                     out_player,
  input  logic                     out_ack,
  output logic                     ovf1,
  output logic                     ovf2,
  input  logic                     clr_ovf,
  output logic [$clog2(DEPTH):0]   p1_count,
  output logic [$clog2(DEPTH):0]   p2_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {S_EMPTY, S_HOLD} state_t;

  state_t state, state_n;

  logic [CODE_W-1:0] mem [2][DEPTH];
  logic [AW-1:0]     rd_ptr [2];
  logic [AW-1:0]     wr_ptr [2];
  logic [CW-1:0]     count  [2];
  logic [1:0]        ovf;
  logic              last_grant;

  logic [1:0]        in_v;
  logic [CODE_W-1:0] in_c [2];
  logic [1:0]        nonempty;
  logic [1:0]        rep;
  logic [1:0]        push_ok;
  logic [1:0]        drop;
  logic [1:0]        pop;
  logic              load;
  logic              take;
  logic              sel;

`ifdef KEY_ARB_REPEAT_FILTER_EN
  logic [CODE_W-1:0] last_code [2];
`endif

  always_comb begin
    in_v    = {p2_valid, p1_valid};
    in_c[0] = p1_code;
    in_c[1] = p2_code;
    for (int i = 0; i < 2; i++) begin
      nonempty[i] = (count[i] != '0);
    end
`ifdef KEY_ARB_REPEAT_FILTER_EN
    for (int i = 0; i < 2; i++) begin
      rep[i] = in_v[i] && (in_c[i] == last_code[i]);
    end
`else
    rep = '0;
`endif
    // Tie goes to the channel not granted last time.
    sel  = nonempty[1] & (~nonempty[0] | ~last_grant);
    load = (state == S_EMPTY) || out_ack;
    take = load && (|nonempty);
    pop  = {take & sel, take & ~sel};
    for (int i = 0; i < 2; i++) begin
      push_ok[i] = in_v[i] && !rep[i] &&
                   ((count[i] != CW'(DEPTH)) || pop[i]);
      drop[i]    = in_v[i] && !rep[i] && !push_ok[i];
    end
    state_n = state;
    unique case (state)
      S_EMPTY: if (take) state_n = S_HOLD;
      S_HOLD:  if (out_ack && !take) state_n = S_EMPTY;
      default: state_n = S_EMPTY;
    endcase
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (push_ok[i]) mem[i][wr_ptr[i]] <= in_c[i];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_EMPTY;
      out_code   <= '0;
      out_player <= 1'b0;
      last_grant <= 1'b1;
      ovf        <= '0;
      for (int i = 0; i < 2; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
`ifdef KEY_ARB_REPEAT_FILTER_EN
        last_code[i] <= '0;
`endif
      end
    end else begin
      state <= state_n;
      if (take) begin
        out_code   <= mem[sel][rd_ptr[sel]];
        out_player <= sel;
        last_grant <= sel;
      end
      for (int i = 0; i < 2; i++) begin
        if (push_ok[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])     rd_ptr[i] <= rd_ptr[i] + 1'b1;
        count[i] <= count[i] + CW'(push_ok[i]) - CW'(pop[i]);
        if (drop[i])     ovf[i] <= 1'b1;
        else if (clr_ovf) ovf[i] <= 1'b0;
`ifdef KEY_ARB_REPEAT_FILTER_EN
        if (push_ok[i]) last_code[i] <= in_c[i];
`endif
      end
    end
  end

  assign out_valid = (state == S_HOLD);
  assign ovf1      = ovf[0];
  assign ovf2      = ovf[1];
  assign p1_count  = count[0];
  assign p2_count  = count[1];

endmodule

// File: tb/tb_ps2_key_arbiter.sv
// Scoreboard bench for ps2_key_arbiter: driver queues expected events,
// a negedge monitor checks each acknowledged delivery.
module tb_ps2_key_arbiter;

  localparam int DEPTH  = 4;
  localparam int CODE_W = 8;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              clock = 1'b0;
  logic              reset;
  logic              p1_valid, p2_valid;
  logic [CODE_W-1:0] p1_code, p2_code;
  logic              out_valid;
  logic [CODE_W-1:0] out_code;
  logic              out_player;
  logic              out_ack;
  logic              ovf1, ovf2;
  logic              clr_ovf;
  logic [CW-1:0]     p1_count, p2_count;

  typedef struct packed {
    logic              player;
    logic [CODE_W-1:0] code;
  } ev_t;

  ev_t exp_q[$];
  int  n_vec = 0;
  int  n_bad = 0;

  ps2_key_arbiter #(.DEPTH(DEPTH), .CODE_W(CODE_W)) dut (
    .clock(clock), .reset(reset),
    .p1_valid(p1_valid), .p1_code(p1_code),
    .p2_valid(p2_valid), .p2_code(p2_code),
    .out_valid(out_valid), .out_code(out_code),
    .out_player(out_player), .out_ack(out_ack),
    .ovf1(ovf1), .ovf2(ovf2), .clr_ovf(clr_ovf),
    .p1_count(p1_count), .p2_count(p2_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset && out_valid && out_ack) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL deliver: got %0d/%0h expected nothing",
                 out_player, out_code);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        chk("deliver", {23'd0, out_player, out_code},
            {23'd0, e.player, e.code});
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_ev(input logic pl, input logic [CODE_W-1:0] c);
    ev_t e;
    e.player = pl;
    e.code   = c;
    exp_q.push_back(e);
  endtask

  task automatic push(input logic v1, input logic [CODE_W-1:0] c1,
                      input logic v2, input logic [CODE_W-1:0] c2);
    p1_valid = v1; p1_code = c1;
    p2_valid = v2; p2_code = c2;
    tick();
    p1_valid = 1'b0;
    p2_valid = 1'b0;
  endtask

  task automatic drain();
    out_ack = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      tick();
    end
    chk("drain_left", exp_q.size(), 0);
    out_ack = 1'b0;
  endtask

  task automatic do_reset();
    out_ack = 1'b0;
    reset   = 1'b1;
    exp_q.delete();
    tick();
    reset   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    p1_valid = 1'b0; p2_valid = 1'b0;
    p1_code = '0; p2_code = '0;
    out_ack = 1'b0; clr_ovf = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    chk("rst_valid", out_valid, 0);
    chk("rst_code", out_code, 0);
    chk("rst_player", out_player, 0);
    chk("rst_ovf1", ovf1, 0);
    chk("rst_ovf2", ovf2, 0);
    chk("rst_p1_count", p1_count, 0);
    chk("rst_p2_count", p2_count, 0);

    // single event latency and ack
    expect_ev(1'b0, 8'h75);
    push(1'b1, 8'h75, 1'b0, 8'h00);
    chk("lat_valid_n0", out_valid, 0);
    chk("lat_p1_count_n0", p1_count, 1);
    tick();
    chk("lat_valid_n1", out_valid, 1);
    chk("lat_code_n1", out_code, 8'h75);
    chk("lat_player_n1", out_player, 0);
    chk("lat_p1_count_n1", p1_count, 0);
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
    chk("ack_valid", out_valid, 0);
    chk("ack_p1_count", p1_count, 0);
    chk("ack_left", exp_q.size(), 0);

    // simultaneous pushes alternate, player 1 first after reset
    do_reset();
    out_ack = 1'b1;
    expect_ev(1'b0, 8'h6B);
    expect_ev(1'b1, 8'h1D);
    push(1'b1, 8'h6B, 1'b1, 8'h1D);
    tick();
    tick();
    tick();
    expect_ev(1'b0, 8'h15);
    expect_ev(1'b1, 8'h24);
    push(1'b1, 8'h15, 1'b1, 8'h24);
    drain();

    // p2 overflow with ack low
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (i < 5) expect_ev(1'b1, 8'h30 + 8'(i));
      push(1'b0, 8'h00, 1'b1, 8'h30 + 8'(i));
    end
    chk("ovf_ovf2", ovf2, 1);
    chk("ovf_ovf1", ovf1, 0);
    chk("ovf_p2_count", p2_count, 4);
    chk("ovf_out_code", out_code, 8'h30);
    chk("ovf_out_player", out_player, 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("clr_ovf2", ovf2, 0);
    drain();

    // full FIFO: push with same-cycle pop is accepted
    do_reset();
    for (int i = 0; i < 5; i++) begin
      expect_ev(1'b0, 8'h40 + 8'(i));
      push(1'b1, 8'h40 + 8'(i), 1'b0, 8'h00);
    end
    chk("full_p1_count", p1_count, 4);
    expect_ev(1'b0, 8'h45);
    out_ack = 1'b1;
    push(1'b1, 8'h45, 1'b0, 8'h00);
    out_ack = 1'b0;
    chk("full_pop_count", p1_count, 4);
    chk("full_pop_ovf1", ovf1, 0);
    drain();

    // asynchronous reset mid-handshake
    do_reset();
    push(1'b1, 8'h50, 1'b1, 8'h60);
    push(1'b1, 8'h51, 1'b1, 8'h61);
    chk("pre_async_valid", out_valid, 1);
    #2 reset = 1'b1;
    #1;
    exp_q.delete();
    chk("async_valid", out_valid, 0);
    chk("async_code", out_code, 0);
    chk("async_player", out_player, 0);
    chk("async_p1_count", p1_count, 0);
    chk("async_p2_count", p2_count, 0);
    tick();
    reset = 1'b0;
    expect_ev(1'b0, 8'h77);
    push(1'b1, 8'h77, 1'b0, 8'h00);
    tick();
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_code", out_code, 8'h77);
    drain();

    // repeated codes
    do_reset();
    out_ack = 1'b1;
    expect_ev(1'b0, 8'h75);
`ifndef KEY_ARB_REPEAT_FILTER_EN
    expect_ev(1'b0, 8'h75);
`endif
    expect_ev(1'b0, 8'h72);
    expect_ev(1'b0, 8'h75);
    push(1'b1, 8'h75, 1'b0, 8'h00);
    push(1'b1, 8'h75, 1'b0, 8'h00);
    push(1'b1, 8'h72, 1'b0, 8'h00);
    push(1'b1, 8'h75, 1'b0, 8'h00);
    drain();
    chk("rep_ovf1", ovf1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
